n_clic_timer: RTL and testbench

//  CSR-mapped periodic/one-shot timer. It is the interrupt *source* side of the n_clic request/ack protocol.

---
 rtl/n_clic_timer_pkg.sv | 33 +++
 rtl/n_clic_timer_csr_rmw.sv | 38 +++
 rtl/n_clic_timer.sv | 139 +++++++++++++
 tb/tb_n_clic_timer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/n_clic_timer_pkg.sv
// Shared types and constants for the n_clic timer slice.
package n_clic_timer_pkg;

  typedef logic [31:0] word;
  typedef logic [4:0]  r;
  typedef logic [11:0] CsrAddrT;

  // RISC-V funct3 encodings for the Zicsr instructions.
  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_t;

  // Which timer register the current CSR access targets.
  typedef enum logic [1:0] {
    SEL_CTRL,
    SEL_CMP,
    SEL_CNT,
    SEL_NONE
  } timer_sel_t;

  localparam CsrAddrT     TimerCsrBase     = 12'h7C0;
  localparam int unsigned TimerCtrlEn      = 0;
  localparam int unsigned TimerCtrlOneshot = 1;
  localparam int unsigned TimerCtrlPend    = 2;
  localparam int unsigned TimerPscLsb      = 4;
  localparam int unsigned TimerPscMsb      = 7;

endpackage

// File: rtl/n_clic_timer_csr_rmw.sv
// Combinational CSR read-modify-write: derives the new register value and
// whether the instruction actually writes.
module csr_rmw
  import n_clic_timer_pkg::*;
(
  input  word     old_data,
  input  word     opnd,
  input  csr_op_t csr_op,
  input  r        rs1_zimm,
  output word     new_data,
  output logic    write
);

  // Set/clear forms with a zero rs1 index / zimm are pure reads.
  always_comb begin
    new_data = old_data;
    write    = 1'b0;
    case (csr_op)
      CSR_RW, CSR_RWI: begin
        new_data = opnd;
        write    = 1'b1;
      end
      CSR_RS, CSR_RSI: begin
        new_data = old_data | opnd;
        write    = (rs1_zimm != '0);
      end
      CSR_RC, CSR_RCI: begin
        new_data = old_data & ~opnd;
        write    = (rs1_zimm != '0);
      end
      default: begin
        new_data = old_data;
        write    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/n_clic_timer.sv
// CSR-mapped periodic / one-shot timer; interrupt source for one n_clic vector.
module n_clic_timer
  import n_clic_timer_pkg::*;
#(
  parameter int unsigned CntWidth = 32,
  parameter CsrAddrT     CsrBase  = TimerCsrBase
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    csr_enable,
  input  CsrAddrT csr_addr,
  input  csr_op_t csr_op,
  input  r        rs1_zimm,
  input  word     rs1_data,
  output word     csr_out,
  input  logic    int_ack,
  output logic    int_pending
);

  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic                en;
  logic                oneshot;
  logic [3:0]          psc;
  logic [CntWidth-1:0] cnt;
  logic [CntWidth-1:0] cmp;
  logic [15:0]         presc;
  logic [15:0]         psc_lim;

  CsrAddrT    csr_off;
  timer_sel_t sel;
  word        opnd;
  word        new_data;
  logic       rmw_write;
  logic       ctrl_we;
  logic       cmp_we;
  logic       cnt_we;
  logic       tick;
  logic       evt;

  assign csr_off = csr_addr - CsrBase;

  // Address decode into a register select.
  always_comb begin
    sel = SEL_NONE;
    if (csr_enable) begin
      case (csr_off)
        12'd0:   sel = SEL_CTRL;
        12'd1:   sel = SEL_CMP;
        12'd2:   sel = SEL_CNT;
        default: sel = SEL_NONE;
      endcase
    end
  end

  // Read mux: pre-write value of the addressed register, zero otherwise.
  always_comb begin
    csr_out = '0;
    case (sel)
      SEL_CTRL: begin
        csr_out[TimerCtrlEn]               = en;
        csr_out[TimerCtrlOneshot]          = oneshot;
        csr_out[TimerCtrlPend]             = int_pending;
        csr_out[TimerPscMsb:TimerPscLsb]   = psc;
      end
      SEL_CMP:  csr_out[CntWidth-1:0] = cmp;
      SEL_CNT:  csr_out[CntWidth-1:0] = cnt;
      default:  csr_out = '0;
    endcase
  end

  // Operand selection: immediate forms zero-extend zimm.
  always_comb begin
    opnd = rs1_data;
    if (csr_op inside {CSR_RWI, CSR_RSI, CSR_RCI}) opnd = word'(rs1_zimm);
  end

  csr_rmw u_csr_rmw (
    .old_data (csr_out),
    .opnd     (opnd),
    .csr_op   (csr_op),
    .rs1_zimm (rs1_zimm),
    .new_data (new_data),
    .write    (rmw_write)
  );

  assign ctrl_we = rmw_write && (sel == SEL_CTRL);
  assign cmp_we  = rmw_write && (sel == SEL_CMP);
  assign cnt_we  = rmw_write && (sel == SEL_CNT);

  assign psc_lim = (16'd1 << psc) - 16'd1;
  assign tick    = en && (presc == psc_lim);
  // Event detection always sees the pre-write CNT/CMP.
  assign evt     = tick && (cnt == cmp);

  // Prescaler: free-runs while enabled, wraps on tick, cleared on any CTRL write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 presc <= '0;
    else if (!en || ctrl_we)   presc <= '0;
    else if (tick)             presc <= '0;
    else                       presc <= presc + 16'd1;
  end

  // Counter: CSR write takes priority over the tick update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cnt <= '0;
    else if (cnt_we)  cnt <= new_data[CntWidth-1:0];
    else if (tick)    cnt <= evt ? '0 : cnt + CntOne;
  end

  // Compare register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cmp <= '1;
    else if (cmp_we)  cmp <= new_data[CntWidth-1:0];
  end

  // Control fields; a CTRL write overrides the one-shot EN clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en      <= 1'b0;
      oneshot <= 1'b0;
      psc     <= '0;
    end else if (ctrl_we) begin
      en      <= new_data[TimerCtrlEn];
      oneshot <= new_data[TimerCtrlOneshot];
      psc     <= new_data[TimerPscMsb:TimerPscLsb];
    end else if (evt && oneshot) begin
      en      <= 1'b0;
    end
  end

  // Pending: hardware event set dominates both ack and software clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) int_pending <= 1'b0;
    else       int_pending <= evt | (ctrl_we ? new_data[TimerCtrlPend]
                                             : (int_pending & ~int_ack));
  end

endmodule

// File: tb/tb_n_clic_timer.sv
// Scoreboard bench for n_clic_timer: driver pushes expectations from a
// behavioural model, a monitor pops and compares them each cycle.
module tb_n_clic_timer;
  import n_clic_timer_pkg::*;

  localparam CsrAddrT A_CTRL = TimerCsrBase;
  localparam CsrAddrT A_CMP  = TimerCsrBase + 12'd1;
  localparam CsrAddrT A_CNT  = TimerCsrBase + 12'd2;
  localparam CsrAddrT A_BAD  = TimerCsrBase + 12'd3;

  logic    clk = 1'b0;
  logic    reset;
  logic    csr_enable;
  CsrAddrT csr_addr;
  csr_op_t csr_op;
  r        rs1_zimm;
  word     rs1_data;
  word     csr_out;
  logic    int_ack;
  logic    int_pending;

  always #5 clk = ~clk;

  n_clic_timer #(.CntWidth(32), .CsrBase(TimerCsrBase)) dut (
    .clk         (clk),
    .reset       (reset),
    .csr_enable  (csr_enable),
    .csr_addr    (csr_addr),
    .csr_op      (csr_op),
    .rs1_zimm    (rs1_zimm),
    .rs1_data    (rs1_data),
    .csr_out     (csr_out),
    .int_ack     (int_ack),
    .int_pending (int_pending)
  );

  typedef struct {
    word         out;
    bit          pend;
    int unsigned id;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned issued = 0;

  // Behavioural model state.
  bit          m_en, m_os, m_pend;
  int unsigned m_psc;
  word         m_cmp, m_cnt;
  int unsigned m_presc;   // enabled cycles since the prescaler was last cleared

  function automatic word m_ctrl();
    return word'(m_en) | (word'(m_os) << 1) | (word'(m_pend) << 2) | (word'(m_psc) << 4);
  endfunction

  function automatic void model_reset();
    m_en = 0; m_os = 0; m_pend = 0; m_psc = 0;
    m_cmp = 32'hFFFF_FFFF; m_cnt = 0; m_presc = 0;
  endfunction

  // One cycle: drive, record expected outputs, then advance the model past the edge.
  task automatic cyc(input bit rst, input bit en_i, input CsrAddrT a, input csr_op_t op,
                     input r z, input word d, input bit ack);
    CsrAddrT     off;
    bit          hit, wr, imm, tick, evt, ctrl_w;
    word         old, opnd, nv;
    int unsigned period;
    @(negedge clk);
    #1;
    reset = rst; csr_enable = en_i; csr_addr = a; csr_op = op;
    rs1_zimm = z; rs1_data = d; int_ack = ack;
    if (rst) model_reset();
    off = a - TimerCsrBase;
    hit = en_i && (off < 12'd3);
    old = !hit ? 32'd0 : (off == 12'd0) ? m_ctrl() : (off == 12'd1) ? m_cmp : m_cnt;
    sb.push_back('{old, m_pend, issued});
    issued++;
    if (!rst) begin
      imm  = (op == CSR_RWI) || (op == CSR_RSI) || (op == CSR_RCI);
      opnd = imm ? {27'd0, z} : d;
      nv = old; wr = 0;
      if (op == CSR_RW || op == CSR_RWI) begin nv = opnd; wr = 1; end
      else if (op == CSR_RS || op == CSR_RSI) begin nv = old | opnd; wr = (z != 0); end
      else begin nv = old & ~opnd; wr = (z != 0); end
      wr = wr && hit;
      ctrl_w = wr && (off == 12'd0);
      period = 32'd1 << m_psc;
      tick = m_en && ((m_presc % period) == period - 1);
      evt  = tick && (m_cnt == m_cmp);
      m_pend  = evt || (ctrl_w ? nv[2] : (m_pend && !ack));
      m_presc = (!m_en || ctrl_w) ? 0 : m_presc + 1;
      if (wr && off == 12'd2) m_cnt = nv;
      else if (tick)          m_cnt = evt ? 32'd0 : m_cnt + 32'd1;
      if (wr && off == 12'd1) m_cmp = nv;
      if (ctrl_w) begin
        m_en = nv[0]; m_os = nv[1]; m_psc = int'(nv[7:4]);
      end else if (evt && m_os) begin
        m_en = 0;
      end
    end
  endtask

  task automatic rd(input CsrAddrT a);
    cyc(0, 1, a, CSR_RS, 5'd0, 32'd0, 0);
  endtask

  task automatic wr(input CsrAddrT a, input word v);
    cyc(0, 1, a, CSR_RW, 5'd1, v, 0);
  endtask

  // Monitor: compare just before each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (csr_out !== e.out) begin
          errors++;
          $display("FAIL csr_out item %0d: got %h expected %h", e.id, csr_out, e.out);
        end
        checks++;
        if (int_pending !== e.pend) begin
          errors++;
          $display("FAIL int_pending item %0d: got %b expected %b", e.id, int_pending, e.pend);
        end
      end
    end
  end

  initial begin
    csr_op_t ops[6];
    int unsigned sel;
    CsrAddrT a;
    ops = '{CSR_RW, CSR_RS, CSR_RC, CSR_RWI, CSR_RSI, CSR_RCI};
    reset = 1; csr_enable = 0; csr_addr = '0; csr_op = CSR_RS;
    rs1_zimm = '0; rs1_data = '0; int_ack = 0;
    model_reset();

    cyc(1, 1, A_CTRL, CSR_RS, 0, 0, 0);
    cyc(1, 1, A_CMP, CSR_RS, 0, 0, 0);

    // Reset asserted mid-count.
    wr(A_CMP, 10); wr(A_CNT, 5); wr(A_CTRL, 1);
    rd(A_CNT); rd(A_CNT);
    cyc(1, 1, A_CNT,  CSR_RS, 0, 0, 0);
    cyc(1, 1, A_CMP,  CSR_RS, 0, 0, 0);
    cyc(1, 1, A_CTRL, CSR_RS, 0, 0, 0);

    // Periodic, PSC=0.
    wr(A_CMP, 3); wr(A_CTRL, 1);
    for (int i = 0; i < 14; i++) rd(A_CNT);
    cyc(0, 1, A_CTRL, CSR_RS, 0, 0, 1);
    wr(A_CTRL, 0); wr(A_CNT, 0);

    // Prescale + one-shot.
    wr(A_CMP, 1); wr(A_CTRL, 32'h23);
    for (int i = 0; i < 12; i++) rd(A_CTRL);
    rd(A_CNT);

    // Ack colliding with events, then disable and ack.
    wr(A_CTRL, 0); wr(A_CNT, 0); wr(A_CMP, 0); wr(A_CTRL, 1);
    rd(A_CTRL); rd(A_CTRL);
    cyc(0, 1, A_CTRL, CSR_RS, 0, 0, 1);
    rd(A_CTRL);
    cyc(0, 1, A_CTRL, CSR_RCI, 5'd1, 0, 0);
    cyc(0, 1, A_CTRL, CSR_RS, 0, 0, 1);
    rd(A_CTRL); rd(A_CTRL);

    // CSR ops.
    cyc(0, 1, A_CTRL, CSR_RSI, 5'd4, 0, 0);
    rd(A_CTRL);
    cyc(0, 1, A_CTRL, CSR_RC, 5'd0, 32'hFFFF_FFFF, 0);
    rd(A_CTRL);
    cyc(0, 1, A_CTRL, CSR_RCI, 5'd4, 0, 0);
    rd(A_CTRL);
    wr(A_CMP, 100); wr(A_CTRL, 1);
    rd(A_CNT); rd(A_CNT); rd(A_CNT);
    wr(A_CNT, 50);
    rd(A_CNT); rd(A_CNT);

    // Address decode.
    cyc(0, 1, A_BAD, CSR_RW, 5'd1, 32'd123, 0);
    cyc(0, 0, A_CTRL, CSR_RW, 5'd1, 32'd0, 0);
    cyc(0, 0, A_CNT, CSR_RW, 5'd1, 32'd7, 0);
    rd(A_CTRL); rd(A_CMP); rd(A_CNT);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: a = A_CTRL;
        1: a = A_CMP;
        2: a = A_CNT;
        3: a = A_BAD;
        4: a = TimerCsrBase - 12'd1;
        default: a = CsrAddrT'($urandom);
      endcase
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), a,
          ops[$urandom_range(0, 5)],
          ($urandom_range(0, 3) == 0) ? 5'd0 : r'($urandom_range(0, 31)),
          ($urandom_range(0, 1) == 0) ? word'($urandom_range(0, 7)) : word'($urandom),
          ($urandom_range(0, 7) == 0));
    end
    cyc(0, 0, A_CTRL, CSR_RS, 0, 0, 0);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    #5;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending items expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
